// File: rtl/phase_seq_pkg.sv
// Shared state encoding and default timing constants for phase_sequencer.
package phase_seq_pkg;

   typedef enum logic [1:0] {
      PH_CLEAR  = 2'd0,
      PH_GREEN  = 2'd1,
      PH_YELLOW = 2'd2,
      PH_FLASH  = 2'd3
   } phase_state_e;

   localparam logic [1:0] ST_CLEAR  = PH_CLEAR;
   localparam logic [1:0] ST_GREEN  = PH_GREEN;
   localparam logic [1:0] ST_YELLOW = PH_YELLOW;
   localparam logic [1:0] ST_FLASH  = PH_FLASH;

   localparam int unsigned DEF_NUM_APP   = 4;
   localparam int unsigned DEF_TMR_W     = 8;
   localparam int unsigned DEF_MIN_GREEN = 5;
   localparam int unsigned DEF_MAX_GREEN = 20;
   localparam int unsigned DEF_YEL_TICKS = 3;
   localparam int unsigned DEF_CLR_TICKS = 2;

endpackage

// File: rtl/phase_sequencer_if.sv
// Request/lamp bundle between the intersection controller and its environment.
interface phase_sequencer_if
   import phase_seq_pkg::*;
#(
   parameter int unsigned NUM_APP = DEF_NUM_APP
);
   logic               tick;
   logic [NUM_APP-1:0] req;
   logic               flash_req;
   logic [NUM_APP-1:0] green;
   logic [NUM_APP-1:0] yellow;
   logic               all_red;
   logic               flash;
   logic [NUM_APP-1:0] served;

   modport master (
      output tick, req, flash_req,
      input  green, yellow, all_red, flash, served
   );

   modport slave (
      input  tick, req, flash_req,
      output green, yellow, all_red, flash, served
   );
endinterface

// File: rtl/phase_sequencer_rr_arbiter.sv
// Round-robin search: first set request at or after i_ptr, wrapping past the top index.
module rr_arbiter #(
   parameter  int unsigned NUM_APP = 4,
   localparam int unsigned IDX_W   = $clog2(NUM_APP)
) (
   input  logic [NUM_APP-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_APP-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_valid
);

   always_comb begin
      logic [IDX_W-1:0] pos;
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      pos     = '0;
      for (int unsigned k = 0; k < NUM_APP; k++) begin
         pos = IDX_W'((32'(i_ptr) + k) % NUM_APP);
         if (!o_valid && i_req[pos]) begin
            o_valid      = 1'b1;
            o_idx        = pos;
            o_grant[pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/phase_sequencer.sv
// Traffic phase sequencer: CLEAR -> GREEN -> YELLOW -> CLEAR with round-robin service.
// Optional maintenance flash mode is built only when PHASE_SEQ_FLASH_EN is defined.
module phase_sequencer
   import phase_seq_pkg::*;
#(
   parameter int unsigned NUM_APP   = DEF_NUM_APP,
   parameter int unsigned TMR_W     = DEF_TMR_W,
   parameter int unsigned MIN_GREEN = DEF_MIN_GREEN,
   parameter int unsigned MAX_GREEN = DEF_MAX_GREEN,
   parameter int unsigned YEL_TICKS = DEF_YEL_TICKS,
   parameter int unsigned CLR_TICKS = DEF_CLR_TICKS
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   phase_sequencer_if.slave   io_bus
);

   localparam int unsigned      IDX_W    = $clog2(NUM_APP);
   localparam logic [TMR_W-1:0] TMR_SAT  = '1;
   localparam logic [TMR_W-1:0] MIN_T    = TMR_W'(MIN_GREEN);
   localparam logic [TMR_W-1:0] MAX_T    = TMR_W'(MAX_GREEN);
   localparam logic [TMR_W-1:0] YEL_T    = TMR_W'(YEL_TICKS);
   localparam logic [TMR_W-1:0] CLR_T    = TMR_W'(CLR_TICKS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_APP - 1);

   logic [1:0]         r_state;
   logic [1:0]         w_state_nx;
   logic [TMR_W-1:0]   r_tmr;
   logic [TMR_W-1:0]   w_tmr_nx;
   logic [TMR_W-1:0]   w_tmr_inc;
   logic [IDX_W-1:0]   r_cur;
   logic [IDX_W-1:0]   w_cur_nx;
   logic [IDX_W-1:0]   r_last;
   logic [IDX_W-1:0]   w_last_nx;
   logic [IDX_W-1:0]   w_ptr;
   logic [IDX_W-1:0]   w_arb_idx;
   logic [NUM_APP-1:0] w_arb_grant;
   logic               w_arb_valid;
   logic [NUM_APP-1:0] w_cur_oh;
   logic [NUM_APP-1:0] w_nx_oh;
   logic               w_own;
   logic               w_rival;
   logic               w_green_exit;
   logic               w_serve;
   logic               w_flash_go;
   logic [NUM_APP-1:0] r_green;
   logic [NUM_APP-1:0] r_yellow;
   logic [NUM_APP-1:0] r_served;
   logic               r_all_red;

   assign w_ptr = (r_last == LAST_IDX) ? '0 : r_last + 1'b1;

   rr_arbiter #(
      .NUM_APP (NUM_APP)
   ) u_rr_arbiter (
      .i_req   (io_bus.req),
      .i_ptr   (w_ptr),
      .o_grant (w_arb_grant),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_valid)
   );

   assign w_tmr_inc = (r_tmr == TMR_SAT) ? r_tmr : r_tmr + 1'b1;
   assign w_cur_oh  = NUM_APP'(1) << r_cur;
   assign w_own     = |(io_bus.req & w_cur_oh);
   assign w_rival   = |(io_bus.req & ~w_cur_oh);

   // Idle own request ends green at MIN; a held request yields only to a waiting rival at MAX.
   assign w_green_exit = io_bus.tick &&
                         (((w_tmr_inc >= MIN_T) && !w_own) || (w_rival && (w_tmr_inc >= MAX_T)));

`ifdef PHASE_SEQ_FLASH_EN
   assign w_flash_go = io_bus.flash_req;
`else
   logic w_unused_flash_req;
   assign w_unused_flash_req = io_bus.flash_req;
   assign w_flash_go         = 1'b0;
`endif

   always_comb begin
      w_state_nx = r_state;
      w_tmr_nx   = io_bus.tick ? w_tmr_inc : r_tmr;
      w_cur_nx   = r_cur;
      w_last_nx  = r_last;
      w_nx_oh    = w_cur_oh;
      w_serve    = 1'b0;
      if (w_flash_go) begin
         w_state_nx = ST_FLASH;
         if (r_state != ST_FLASH) w_tmr_nx = '0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               if (io_bus.tick && (w_tmr_inc >= CLR_T) && w_arb_valid) begin
                  w_state_nx = ST_GREEN;
                  w_tmr_nx   = '0;
                  w_cur_nx   = w_arb_idx;
                  w_nx_oh    = w_arb_grant;
               end
            end
            ST_GREEN: begin
               if (w_green_exit) begin
                  w_state_nx = ST_YELLOW;
                  w_tmr_nx   = '0;
                  w_last_nx  = r_cur;
                  w_serve    = 1'b1;
               end
            end
            ST_YELLOW: begin
               if (io_bus.tick && (w_tmr_inc >= YEL_T)) begin
                  w_state_nx = ST_CLEAR;
                  w_tmr_nx   = '0;
               end
            end
            default: begin
               w_state_nx = ST_CLEAR;
               w_tmr_nx   = '0;
            end
         endcase
      end
   end

   // Lamps are registered from next-state so they line up with the state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_CLEAR;
         r_tmr     <= '0;
         r_cur     <= '0;
         r_last    <= LAST_IDX;
         r_green   <= '0;
         r_yellow  <= '0;
         r_served  <= '0;
         r_all_red <= 1'b1;
      end else begin
         r_state   <= w_state_nx;
         r_tmr     <= w_tmr_nx;
         r_cur     <= w_cur_nx;
         r_last    <= w_last_nx;
         r_green   <= (w_state_nx == ST_GREEN)  ? w_nx_oh : '0;
         r_yellow  <= (w_state_nx == ST_YELLOW) ? w_nx_oh : '0;
         r_served  <= w_serve ? w_cur_oh : '0;
         r_all_red <= (w_state_nx == ST_CLEAR);
      end
   end

`ifdef PHASE_SEQ_FLASH_EN
   logic r_flash;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_flash <= 1'b0;
      end else if (w_state_nx != ST_FLASH) begin
         r_flash <= 1'b0;
      end else if (r_state != ST_FLASH) begin
         r_flash <= 1'b1;
      end else if (io_bus.tick) begin
         r_flash <= ~r_flash;
      end
   end

   assign io_bus.flash = r_flash;
`else
   assign io_bus.flash = 1'b0;
`endif

   assign io_bus.green   = r_green;
   assign io_bus.yellow  = r_yellow;
   assign io_bus.all_red = r_all_red;
   assign io_bus.served  = r_served;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed vector bench for phase_sequencer (default timing, NUM_APP=4).
module tb_phase_sequencer;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   phase_sequencer_if #(.NUM_APP(4)) bus ();

   phase_sequencer #(
      .NUM_APP   (4),
      .TMR_W     (8),
      .MIN_GREEN (5),
      .MAX_GREEN (20),
      .YEL_TICKS (3),
      .CLR_TICKS (2)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus)
   );

   typedef struct {
      logic       t;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] y;
      logic [3:0] s;
      logic       a;
   } vec_t;

   vec_t tbl [17];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [3:0] g, input logic [3:0] y,
                      input logic [3:0] s, input logic a, input logic f);
      logic [13:0] act;
      logic [13:0] exp_v;
      act   = {bus.green, bus.yellow, bus.served, bus.all_red, bus.flash};
      exp_v = {g, y, s, a, f};
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s @%0t: got g=%b y=%b s=%b ar=%b fl=%b, expected g=%b y=%b s=%b ar=%b fl=%b",
                  nm, $time, bus.green, bus.yellow, bus.served, bus.all_red, bus.flash,
                  g, y, s, a, f);
      end
   endtask

   task automatic step(input logic t, input logic [3:0] r);
      @(negedge clk);
      bus.tick = t;
      bus.req  = r;
      @(posedge clk);
      #1;
   endtask

   task automatic run_n(input int n, input string nm, input logic [3:0] r,
                        input logic [3:0] g, input logic [3:0] y, input logic a);
      for (int i = 0; i < n; i++) begin
         step(1'b1, r);
         chk(nm, g, y, 4'b0000, a, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      rst_n         = 1'b0;
      bus.tick      = 1'b0;
      bus.req       = 4'b0000;
      bus.flash_req = 1'b0;

      //            tick  req      green    yellow   served   allred
      tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1};
      tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1};
      tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1};
      tbl[3]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1};
      tbl[4]  = '{1'b1, 4'b1010, 4'b0010, 4'b0000, 4'b0000, 1'b0};
      tbl[5]  = '{1'b1, 4'b1010, 4'b0010, 4'b0000, 4'b0000, 1'b0};
      tbl[6]  = '{1'b1, 4'b0100, 4'b0010, 4'b0000, 4'b0000, 1'b0};
      tbl[7]  = '{1'b1, 4'b0100, 4'b0010, 4'b0000, 4'b0000, 1'b0};
      tbl[8]  = '{1'b0, 4'b0100, 4'b0010, 4'b0000, 4'b0000, 1'b0};
      tbl[9]  = '{1'b1, 4'b0100, 4'b0010, 4'b0000, 4'b0000, 1'b0};
      tbl[10] = '{1'b1, 4'b0100, 4'b0000, 4'b0010, 4'b0010, 1'b0};
      tbl[11] = '{1'b1, 4'b0100, 4'b0000, 4'b0010, 4'b0000, 1'b0};
      tbl[12] = '{1'b0, 4'b0100, 4'b0000, 4'b0010, 4'b0000, 1'b0};
      tbl[13] = '{1'b1, 4'b0100, 4'b0000, 4'b0010, 4'b0000, 1'b0};
      tbl[14] = '{1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1};
      tbl[15] = '{1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b1};
      tbl[16] = '{1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("reset", 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle clear, first grant to lowest requester, early green end on own drop.
      for (int i = 0; i < 17; i++) begin
         step(tbl[i].t, tbl[i].r);
         chk($sformatf("vec%0d", i), tbl[i].g, tbl[i].y, tbl[i].s, tbl[i].a, 1'b0);
      end

      // Lone requester holds green with no served pulse.
      run_n(30, "hold_green", 4'b0100, 4'b0100, 4'b0000, 1'b0);

      step(1'b1, 4'b0001);
      chk("hold_release", 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b0);
      run_n(2, "yel_a2", 4'b0101, 4'b0000, 4'b0100, 1'b0);
      run_n(2, "clr_a2", 4'b0101, 4'b0000, 4'b0000, 1'b1);
      step(1'b1, 4'b0101);
      chk("grant_a0", 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);

      // Contested green runs to MAX_GREEN.
      run_n(19, "max_green", 4'b0101, 4'b0001, 4'b0000, 1'b0);
      step(1'b1, 4'b0101);
      chk("max_exit", 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b0);
      run_n(2, "yel_a0", 4'b0101, 4'b0000, 4'b0001, 1'b0);
      run_n(2, "clr_a0", 4'b0101, 4'b0000, 4'b0000, 1'b1);
      step(1'b1, 4'b0101);
      chk("grant_a2", 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0);

      // Serve approach 3, then wrap-around must pick 0 over 3.
      run_n(4, "a2_min", 4'b1000, 4'b0100, 4'b0000, 1'b0);
      step(1'b1, 4'b1000);
      chk("a2_exit", 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b0);
      run_n(2, "yel_a2b", 4'b1000, 4'b0000, 4'b0100, 1'b0);
      run_n(2, "clr_a2b", 4'b1000, 4'b0000, 4'b0000, 1'b1);
      step(1'b1, 4'b1000);
      chk("grant_a3", 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0);
      run_n(2, "a3_own", 4'b1000, 4'b1000, 4'b0000, 1'b0);
      run_n(2, "a3_drop", 4'b0001, 4'b1000, 4'b0000, 1'b0);
      step(1'b1, 4'b0001);
      chk("a3_exit", 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b0);
      run_n(2, "yel_a3", 4'b1001, 4'b0000, 4'b1000, 1'b0);
      run_n(2, "clr_a3", 4'b1001, 4'b0000, 4'b0000, 1'b1);
      step(1'b1, 4'b1001);
      chk("wrap_grant", 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);

`ifdef PHASE_SEQ_FLASH_EN
      bus.flash_req = 1'b1;
      step(1'b1, 4'b1001);
      chk("flash_enter", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
      step(1'b1, 4'b1001);
      chk("flash_toggle", 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      bus.flash_req = 1'b0;
      @(posedge clk);
      #1;
      chk("flash_exit", 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
      run_n(1, "flash_clr", 4'b1001, 4'b0000, 4'b0000, 1'b1);
      step(1'b1, 4'b1001);
      chk("flash_regrant", 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
`else
      bus.flash_req = 1'b1;
      run_n(3, "flash_ignored", 4'b1001, 4'b0001, 4'b0000, 1'b0);
      bus.flash_req = 1'b0;
`endif

      // Reset must act between clock edges.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_reset", 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
